// File: rtl/boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream,
// writes 9-bit words into instruction memory, then releases the core from
// reset and counts its run cycles until it halts or times out.
//
// Byte handshake: a byte transfers on a rising clk edge where rx_valid and
// rx_ready are both 1. rx_ready depends only on the current state and on
// reset, never on rx_valid. rx_valid=0 cycles leave all state untouched.
module boot_loader #(
    parameter int unsigned IW         = 8,
    parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    output logic          imem_we,
    output logic [IW-1:0] imem_addr,
    output logic [8:0]    imem_wdata,
    output logic          cpu_reset,
    input  logic          cpu_done,
    output logic [15:0]   cycle_count,
    output logic          run_done,
    output logic          err,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        ST_LEN   = 3'd0,
        ST_LO    = 3'd1,
        ST_HI    = 3'd2,
        ST_CSUM  = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    n_q, n_d;          // instruction count from the LEN byte
    logic [IW-1:0] idx_q, idx_d;      // index of the word being loaded
    logic [7:0]    csum_q, csum_d;    // running XOR of N and every data byte
    logic [7:0]    lo_q, lo_d;        // low byte of the word in flight
    logic          we_q, we_d;
    logic [IW-1:0] addr_q, addr_d;
    logic [8:0]    wdata_q, wdata_d;
    logic [15:0]   cnt_q, cnt_d;

    logic loading;
    logic accept;
    logic last_word;

    assign loading   = (state_q == ST_LEN) || (state_q == ST_LO) ||
                       (state_q == ST_HI)  || (state_q == ST_CSUM);
    // No byte may be taken while reset is held low.
    assign rx_ready  = reset && loading;
    assign accept    = rx_valid && rx_ready;
    // Compared in 32 bits so the index never has to hold the value N itself.
    assign last_word = ({24'd0, n_q} == (32'(idx_q) + 32'd1));

    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign cpu_reset   = !((state_q == ST_RUN) || (state_q == ST_DONE));
    assign cycle_count = cnt_q;
    assign run_done    = (state_q == ST_DONE);
    assign err         = (state_q == ST_ERROR);
    assign dbg_state   = state_q;

    // Next-state and datapath updates for load, run and terminal states.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        lo_d    = lo_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_LEN: begin
                if (accept) begin
                    if (rx_data == 8'd0) begin
                        state_d = ST_ERROR;
                    end else begin
                        n_d     = rx_data;
                        csum_d  = rx_data;
                        idx_d   = '0;
                        state_d = ST_LO;
                    end
                end
            end
            ST_LO: begin
                if (accept) begin
                    lo_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                if (accept) begin
                    if (rx_data[7:1] != 7'd0) begin
                        state_d = ST_ERROR;
                    end else begin
                        csum_d  = csum_q ^ rx_data;
                        we_d    = 1'b1;
                        addr_d  = idx_q;
                        wdata_d = {rx_data[0], lo_q};
                        idx_d   = idx_q + IW'(1);
                        state_d = last_word ? ST_CSUM : ST_LO;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (rx_data == csum_q) ? ST_RUN : ST_ERROR;
                end
            end
            ST_RUN: begin
                if (cpu_done) begin
                    state_d = ST_DONE;
                end else if (cnt_q == MAX_CYCLES) begin
                    state_d = ST_ERROR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
            end
            ST_ERROR: begin
            end
            default: begin
                state_d = ST_ERROR;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_LEN;
            n_q     <= 8'd0;
            idx_q   <= '0;
            csum_q  <= 8'd0;
            lo_q    <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 9'd0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            lo_q    <= lo_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: randomized and directed load streams, a write
// scoreboard fed by the stimulus, and run/timeout/error/reset checks.
module tb_boot_loader;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          imem_we;
  logic [IW-1:0] imem_addr;
  logic [8:0]    imem_wdata;
  logic          cpu_reset;
  logic          cpu_done;
  logic [15:0]   cycle_count;
  logic          run_done;
  logic          err;
  logic [2:0]    dbg_state;

  // Second instance with a short run limit, fed the same byte stream.
  logic          rx_ready_5;
  logic          imem_we_5;
  logic [IW-1:0] imem_addr_5;
  logic [8:0]    imem_wdata_5;
  logic          cpu_reset_5;
  logic          cpu_done_5;
  logic [15:0]   cycle_count_5;
  logic          run_done_5;
  logic          err_5;
  logic [2:0]    dbg_state_5;

  int n_vec  = 0;
  int n_miss = 0;

  logic [IW+8:0] exp_q[$];      // {addr, wdata} of each expected write
  logic [8:0]    words[0:254];
  logic [7:0]    bad_hi_bits;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  boot_loader #(.IW(IW)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .cpu_done(cpu_done),
    .cycle_count(cycle_count), .run_done(run_done), .err(err),
    .dbg_state(dbg_state)
  );

  boot_loader #(.IW(IW), .MAX_CYCLES(16'd5)) dut5 (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready_5), .imem_we(imem_we_5), .imem_addr(imem_addr_5),
    .imem_wdata(imem_wdata_5), .cpu_reset(cpu_reset_5), .cpu_done(cpu_done_5),
    .cycle_count(cycle_count_5), .run_done(run_done_5), .err(err_5),
    .dbg_state(dbg_state_5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- write monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", imem_addr, imem_wdata);
      end else begin
        check("imem_write", {imem_addr, imem_wdata}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks (entered and left on a negedge) ----------------
  task automatic send_byte(input logic [7:0] b);
    int gap;
    int tries;
    gap = $urandom_range(0, 3);
    tries = 0;
    rx_valid = 1'b0;
    repeat (gap) begin
      rx_data = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    check("byte_accept", rx_ready, 1);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic apply_reset();
    check("writes_outstanding", exp_q.size(), 0);
    exp_q.delete();
    rx_valid = 1'b0;
    cpu_done = 1'b0;
    reset    = 1'b0;
    #1;
    check("rx_ready_in_reset", rx_ready, 0);
    @(negedge clk);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_err", err, 0);
    check("rst_run_done", run_done, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_cycle_count", cycle_count, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_imem_wdata", imem_wdata, 0);
    check("rst5_err", err_5, 0);
    check("rst5_cycle_count", cycle_count_5, 0);
    reset = 1'b1;
    #1;
    check("rx_ready_after_reset", rx_ready, 1);
    @(negedge clk);
  endtask

  // Model of a load: the byte stream is N, then {lo, hi} per word, then the
  // XOR of all preceding bytes; each good HI byte yields one memory write.
  task automatic do_load(input int n, input int bad_hi, input logic [7:0] csum_xor,
                         input int glitch_word, input int abort_word);
    logic [7:0] csum;
    logic [7:0] lo;
    logic [7:0] hi;
    csum = n[7:0];
    send_byte(n[7:0]);
    if (n == 0) begin
      check("len0_err", err, 1);
      check("len0_rx_ready", rx_ready, 0);
      check("len0_cpu_reset", cpu_reset, 1);
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (i == glitch_word) begin
        reset = 1'b0;
        #2;
        reset = 1'b1;
      end
      lo = words[i][7:0];
      hi = {7'd0, words[i][8]};
      send_byte(lo);
      if (i == abort_word) return;
      if (i == bad_hi) begin
        send_byte(hi | bad_hi_bits);
        check("bad_hi_no_write", imem_we, 0);
        check("bad_hi_err", err, 1);
        check("bad_hi_rx_ready", rx_ready, 0);
        return;
      end
      exp_q.push_back({i[IW-1:0], words[i]});
      send_byte(hi);
      check("write_strobe", imem_we, 1);
      csum = csum ^ lo ^ hi;
    end
    send_byte(csum ^ csum_xor);
    if (csum_xor == 8'd0) begin
      check("load_cpu_reset", cpu_reset, 0);
      check("load_err", err, 0);
      check("load_count0", cycle_count, 0);
      check("load_rx_ready", rx_ready, 0);
    end else begin
      check("csum_err", err, 1);
      check("csum_cpu_reset", cpu_reset, 1);
      check("csum_rx_ready", rx_ready, 0);
    end
    check("load_run_done", run_done, 0);
  endtask

  // Core runs k cycles, then halts; result must stay frozen for hold cycles.
  task automatic run_phase(input int k, input int hold);
    cpu_done = 1'b0;
    for (int j = 0; j < k; j++) begin
      check("run_count", cycle_count, j);
      check("run_cpu_reset", cpu_reset, 0);
      @(negedge clk);
    end
    cpu_done = 1'b1;
    @(negedge clk);
    for (int j = 0; j < hold; j++) begin
      cpu_done = 1'($urandom_range(0, 1));
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom);
      check("done_run_done", run_done, 1);
      check("done_count", cycle_count, k);
      check("done_cpu_reset", cpu_reset, 0);
      check("done_rx_ready", rx_ready, 0);
      check("done_err", err, 0);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    cpu_done = 1'b0;
  endtask

  task automatic err_hold(input int cycles);
    logic [15:0] c0;
    c0 = cycle_count;
    for (int j = 0; j < cycles; j++) begin
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom);
      cpu_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("err_sticky", err, 1);
      check("err_rx_ready", rx_ready, 0);
      check("err_cpu_reset", cpu_reset, 1);
      check("err_imem_we", imem_we, 0);
      check("err_count_frozen", cycle_count, c0);
    end
    rx_valid = 1'b0;
    cpu_done = 1'b0;
  endtask

  task automatic set_demo_words();
    words[0] = 9'h1A5;
    words[1] = 9'h003;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int mode;
    reset      = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'd0;
    cpu_done   = 1'b0;
    cpu_done_5 = 1'b0;
    bad_hi_bits = 8'h02;
    @(negedge clk);
    apply_reset();

    // Demo stream: 02 A5 01 03 00 A5, then a 10-cycle run.
    set_demo_words();
    do_load(2, -1, 8'h00, -1, -1);
    run_phase(10, 20);

    // Wrong checksum byte (00 instead of A5).
    apply_reset();
    set_demo_words();
    do_load(2, -1, 8'hA5, -1, -1);
    err_hold(8);

    // HI byte 02 on word 0.
    apply_reset();
    words[0] = 9'h0A5;
    words[1] = 9'h003;
    bad_hi_bits = 8'h02;
    do_load(2, 0, 8'h00, -1, -1);
    err_hold(6);

    // Zero length.
    apply_reset();
    do_load(0, -1, 8'h00, -1, -1);
    err_hold(6);

    // Run timeout on the short-limit instance.
    apply_reset();
    set_demo_words();
    do_load(2, -1, 8'h00, -1, -1);
    for (int j = 0; j <= 5; j++) begin
      check("to_count", cycle_count_5, j);
      check("to_err_low", err_5, 0);
      @(negedge clk);
    end
    check("to_err", err_5, 1);
    check("to_count_max", cycle_count_5, 5);
    check("to_cpu_reset", cpu_reset_5, 1);
    check("to_rx_ready", rx_ready_5, 0);
    repeat (10) @(negedge clk);
    check("to_count_frozen", cycle_count_5, 5);
    check("to_err_sticky", err_5, 1);

    // Reset after LO byte of word 1, then a full reload.
    apply_reset();
    set_demo_words();
    do_load(2, -1, 8'h00, -1, 1);
    apply_reset();
    do_load(2, -1, 8'h00, -1, -1);
    run_phase(3, 4);

    // Reset pulse between edges must be ignored.
    apply_reset();
    set_demo_words();
    do_load(2, -1, 8'h00, 1, -1);
    run_phase(2, 3);

    // Reset in the middle of a run.
    apply_reset();
    set_demo_words();
    do_load(2, -1, 8'h00, -1, -1);
    repeat (4) @(negedge clk);
    check("midrun_count", cycle_count, 4);
    apply_reset();

    // Randomized loads, including a full 255-word image.
    for (int it = 0; it < 14; it++) begin
      n = (it == 5) ? 255 : $urandom_range(1, 10);
      for (int i = 0; i < n; i++) words[i] = 9'($urandom);
      mode = (it == 5) ? 0 : $urandom_range(0, 3);
      if (mode <= 1) begin
        do_load(n, -1, 8'h00, -1, -1);
        if (n == 255) check("last_addr", imem_addr, 254);
        run_phase($urandom_range(0, 15), $urandom_range(2, 6));
      end else if (mode == 2) begin
        do_load(n, -1, 8'($urandom_range(1, 255)), -1, -1);
        err_hold(4);
      end else begin
        bad_hi_bits = 8'($urandom_range(1, 127) << 1);
        do_load(n, $urandom_range(0, n - 1), 8'h00, -1, -1);
        err_hold(4);
      end
      apply_reset();
    end

    check("final_writes_outstanding", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
